control_unit: RTL

- Fetch/decode/execute sequencer for the 6-bit-address accumulator machine.
- Sits directly upstream of the program counter and drives its clr/load/inc strobes.
- Also drives IR load, the memory address-source select, memory read/write strobes, the accumulator load and the ALU operation.
- Adds a memory ready handshake with a bounded wait-state watchdog.

---
 rtl/cu_pkg.sv | 37 +++
 rtl/cu_wait_timer.sv | 33 +++
 rtl/control_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the accumulator machine: opcodes, sequencer states, ALU codes.
package cu_pkg;

  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned ALU_OP_W = 2;

  // Opcode field of the instruction register
  localparam logic [OPCODE_W-1:0] OP_HLT = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_LDA = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_STA = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_SUB = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_JMP = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_NOP = 3'b111;

  // ALU operation select
  localparam logic [ALU_OP_W-1:0] ALU_PASS = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 2'b10;

  // Sequencer state encoding
  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXEC_RD = 3'd3,
    ST_EXEC_WR = 3'd4,
    ST_HALT    = 3'd5
  } cu_state_e;

  // True for states that hold a memory request open until mem_ready
  function automatic logic is_mem_state(input cu_state_e st);
    return (st == ST_FETCH) || (st == ST_EXEC_RD) || (st == ST_EXEC_WR);
  endfunction

endpackage

// File: rtl/cu_wait_timer.sv
// Wait-state watchdog: counts consecutive unanswered memory cycles and pulses
// timeout_c on the WAIT_LIMIT-th one.
module cu_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned WCNT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_en,
  output logic timeout_c
);

  localparam logic [WCNT_W-1:0] LIMIT_M1 = WCNT_W'(WAIT_LIMIT - 1);

  logic [WCNT_W-1:0] cnt_q;

  // This cycle is the last permitted wait cycle and memory is still not ready
  always_comb begin
    timeout_c = wait_en && (cnt_q == LIMIT_M1);
  end

  // Count only uninterrupted waiting; any completion, state change or timeout restarts it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!wait_en || timeout_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + WCNT_W'(1);
    end
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 6-bit-address accumulator machine.
// Drives PC, IR, memory and accumulator strobes combinationally from state.
module control_unit
  import cu_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned WCNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       acc_zero,
  input  logic       mem_ready,
  output logic       pc_clr,
  output logic       pc_load,
  output logic       pc_inc,
  output logic       ir_load,
  output logic       addr_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       acc_load,
  output logic [1:0] alu_op,
  output logic       halted,
  output logic       bus_err
);

  cu_state_e state_q;
  cu_state_e state_d;
  cu_state_e cur_st;
  logic      wait_en;
  logic      timeout_c;
  logic      bus_err_q;

  // While reset is held the outputs already decode as INIT, so no request survives it
  always_comb begin
    cur_st  = rst_n ? state_q : ST_INIT;
    wait_en = is_mem_state(cur_st) && !mem_ready;
  end

  cu_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .WCNT_W     (WCNT_W)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .wait_en   (wait_en),
    .timeout_c (timeout_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Sticky bus error, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_err_q <= 1'b0;
    end else if (timeout_c) begin
      bus_err_q <= 1'b1;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d  = cur_st;
    pc_clr   = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    ir_load  = 1'b0;
    addr_sel = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    acc_load = 1'b0;
    alu_op   = ALU_PASS;
    halted   = 1'b0;

    unique case (cur_st)
      ST_INIT: begin
        pc_clr  = 1'b1;
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        addr_sel = 1'b0;
        mem_rd   = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout_c) begin
          state_d = ST_HALT;
        end
      end

      ST_DECODE: begin
        case (opcode)
          OP_HLT:                 state_d = ST_HALT;
          OP_NOP:                 state_d = ST_FETCH;
          OP_JMP: begin
            pc_load = 1'b1;
            state_d = ST_FETCH;
          end
          OP_JZ: begin
            pc_load = acc_zero;
            state_d = ST_FETCH;
          end
          OP_LDA, OP_ADD, OP_SUB: state_d = ST_EXEC_RD;
          OP_STA:                 state_d = ST_EXEC_WR;
          default:                state_d = ST_HALT;
        endcase
      end

      ST_EXEC_RD: begin
        addr_sel = 1'b1;
        mem_rd   = 1'b1;
        case (opcode)
          OP_ADD:  alu_op = ALU_ADD;
          OP_SUB:  alu_op = ALU_SUB;
          default: alu_op = ALU_PASS;
        endcase
        if (mem_ready) begin
          acc_load = 1'b1;
          state_d  = ST_FETCH;
        end else if (timeout_c) begin
          state_d = ST_HALT;
        end
      end

      ST_EXEC_WR: begin
        addr_sel = 1'b1;
        mem_wr   = 1'b1;
        if (mem_ready) begin
          state_d = ST_FETCH;
        end else if (timeout_c) begin
          state_d = ST_HALT;
        end
      end

      ST_HALT: begin
        halted  = 1'b1;
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // Error flag is a plain view of its register
  always_comb begin
    bus_err = bus_err_q;
  end

endmodule
